// File: rtl/lfsr_capture_fifo.sv
// Capture FIFO for the LFSR application unit: buffers Q samples onto a valid/ready
// stream, tracks drop statistics and measures the LFSR sequence period.
module lfsr_capture_fifo #(
  parameter int n     = 8,
  parameter int DEPTH = 8,
  parameter int PW    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   cap_en,
  input  logic [n-1:0]           Q_in,
  output logic [n-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic [PW-1:0]          period,
  output logic                   period_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  logic [n-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  state_t        state_q;
  logic [n-1:0]  ref_val_q;
  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_inc;
  logic [PW-1:0] period_q;
  logic          period_valid_q;

  logic push, pop, full, do_push, drop, wr_en;

  assign out_valid    = (count_q != '0);
  assign out_data     = mem_q[rd_ptr_q];
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign cnt_inc      = cnt_q + PW'(1);

  // A push into a full FIFO only succeeds when the head leaves on the same edge.
  always_comb begin
    push       = cap_en;
    pop        = out_valid & out_ready;
    full       = (count_q == CW'(DEPTH));
    do_push    = push & (~full | pop);
    drop       = push & full & ~pop;
    wr_en      = do_push & ~clear;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is cleared so out_data reads zero after reset or clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= Q_in;
    end
  end

  // Period FSM counts every capture, dropped or not, until Q returns to its first value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ref_val_q      <= '0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else if (clear) begin
      state_q        <= IDLE;
      ref_val_q      <= '0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cap_en) begin
            ref_val_q <= Q_in;
            cnt_q     <= '0;
            state_q   <= COUNT;
          end
        end
        COUNT: begin
          if (cap_en) begin
            cnt_q <= cnt_inc;
            if (Q_in == ref_val_q) begin
              period_q       <= cnt_inc;
              period_valid_q <= 1'b1;
              state_q        <= DONE;
            end else if (cnt_inc == '1) begin
              period_q       <= '1;
              period_valid_q <= 1'b1;
              state_q        <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_capture_fifo.sv
// Directed bench for lfsr_capture_fifo: per-cycle vector table plus reset and
// period-timeout sequences on a second, PW=4 instance.
module tb_lfsr_capture_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        clear, cap_en, out_ready;
  logic [7:0]  q_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [15:0] period;
  logic        period_valid;

  logic        clear2, cap_en2, out_ready2;
  logic [7:0]  q_in2;
  logic [7:0]  out_data2;
  logic        out_valid2;
  logic [3:0]  count2;
  logic        overflow2;
  logic [7:0]  drop_cnt2;
  logic [3:0]  period2;
  logic        period_valid2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lfsr_capture_fifo #(.n(8), .DEPTH(8), .PW(16)) dut (
    .clock(clock), .reset(reset), .clear(clear), .cap_en(cap_en), .Q_in(q_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
    .period(period), .period_valid(period_valid)
  );

  lfsr_capture_fifo #(.n(8), .DEPTH(8), .PW(4)) dut4 (
    .clock(clock), .reset(reset), .clear(clear2), .cap_en(cap_en2), .Q_in(q_in2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .count(count2), .overflow(overflow2), .drop_cnt(drop_cnt2),
    .period(period2), .period_valid(period_valid2)
  );

  typedef struct {
    logic        cap;
    logic [7:0]  q;
    logic        rdy;
    logic        clr;
    logic [3:0]  e_cnt;
    logic        e_val;
    logic [7:0]  e_data;
    logic        e_ovf;
    logic [7:0]  e_drop;
    logic        e_pv;
    logic [15:0] e_per;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic cap, input logic [7:0] q, input logic rdy,
                              input logic clr, input int e_cnt, input logic e_val,
                              input logic [7:0] e_data, input logic e_ovf,
                              input int e_drop, input logic e_pv, input int e_per);
    vec_t v;
    v.cap = cap; v.q = q; v.rdy = rdy; v.clr = clr;
    v.e_cnt = 4'(e_cnt); v.e_val = e_val; v.e_data = e_data; v.e_ovf = e_ovf;
    v.e_drop = 8'(e_drop); v.e_pv = e_pv; v.e_per = 16'(e_per);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic build_table();
    // Basic capture then drain.
    add(1, 8'h78, 0, 0, 1, 1, 8'h78, 0, 0, 0, 0);
    add(1, 8'h3C, 0, 0, 2, 1, 8'h78, 0, 0, 0, 0);
    add(1, 8'h1E, 0, 0, 3, 1, 8'h78, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 2, 1, 8'h3C, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 8'h1E, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    // Overfill: 10 captures into 8 entries.
    for (int k = 1; k <= 10; k++)
      add(1, 8'(k), 0, 0, (k > 8) ? 8 : k, 1, 8'h01, k > 8, (k > 8) ? k - 8 : 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 8'h00, 1, 0, 8 - i, i < 8, 8'(i + 1), 1, 2, 0, 0);
    // Refill from wrapped pointers, then full push+pop for 4 cycles.
    for (int k = 1; k <= 8; k++)
      add(1, 8'(8'h10 + k), 0, 0, k, 1, 8'h11, 1, 2, 0, 0);
    for (int k = 1; k <= 4; k++)
      add(1, 8'(8'h20 + k), 1, 0, 8, 1, 8'(8'h11 + k), 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 7, 1, 8'h16, 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 6, 1, 8'h17, 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 5, 1, 8'h18, 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 4, 1, 8'h21, 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 3, 1, 8'h22, 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 2, 1, 8'h23, 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 8'h24, 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 2, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    // Period measurement with a cap_en gap.
    add(1, 8'h01, 0, 0, 1, 1, 8'h01, 0, 0, 0, 0);
    add(1, 8'h02, 0, 0, 2, 1, 8'h01, 0, 0, 0, 0);
    add(1, 8'h04, 0, 0, 3, 1, 8'h01, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 3, 1, 8'h01, 0, 0, 0, 0);
    add(1, 8'h08, 0, 0, 4, 1, 8'h01, 0, 0, 0, 0);
    add(1, 8'h10, 0, 0, 5, 1, 8'h01, 0, 0, 0, 0);
    add(1, 8'h01, 0, 0, 6, 1, 8'h01, 0, 0, 1, 5);
    add(1, 8'h02, 0, 0, 7, 1, 8'h01, 0, 0, 1, 5);
    // Clear with a same-cycle capture: sample neither stored nor counted.
    add(1, 8'h55, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    // All-zero lock-up gives period 1.
    add(1, 8'h00, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 2, 1, 8'h00, 0, 0, 1, 1);
    add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    clear = 0; cap_en = 0; out_ready = 0; q_in = '0;
    clear2 = 0; cap_en2 = 0; out_ready2 = 0; q_in2 = '0;
    build_table();

    #3 reset = 1'b1;
    #1;
    chk("rst_async_count", 32'(count), 0);
    chk("rst_async_valid", 32'(out_valid), 0);
    chk("rst_async_data", 32'(out_data), 0);
    chk("rst_async_ovf", 32'(overflow), 0);
    chk("rst_async_drop", 32'(drop_cnt), 0);
    chk("rst_async_pv", 32'(period_valid), 0);
    chk("rst_async_period", 32'(period), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_pv", 32'(period_valid), 0);

    foreach (vecs[i]) begin
      cap_en = vecs[i].cap; q_in = vecs[i].q; out_ready = vecs[i].rdy; clear = vecs[i].clr;
      @(posedge clock); #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_val));
      if (vecs[i].e_val)
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
      chk($sformatf("v%0d_pv", i), 32'(period_valid), 32'(vecs[i].e_pv));
      chk($sformatf("v%0d_period", i), 32'(period), 32'(vecs[i].e_per));
    end
    cap_en = 0; clear = 0; out_ready = 0;

    // PW=4 timeout after 16 distinct captures.
    for (int k = 1; k <= 16; k++) begin
      cap_en2 = 1; q_in2 = 8'(8'h40 + k);
      @(posedge clock); #1;
      chk($sformatf("to%0d_pv", k), 32'(period_valid2), (k == 16) ? 32'd1 : 32'd0);
      if (k == 16) chk("to_period", 32'(period2), 32'hF);
    end
    cap_en2 = 0;
    @(posedge clock); #1;
    chk("to_hold_period", 32'(period2), 32'hF);
    cap_en2 = 1; q_in2 = 8'hA5; clear2 = 1; out_ready2 = 1;
    @(posedge clock); #1;
    chk("clr_cap_count", 32'(count2), 0);
    chk("clr_cap_pv", 32'(period_valid2), 0);
    cap_en2 = 0; clear2 = 0; out_ready2 = 0;
    @(posedge clock); #1;
    chk("clr_cap_valid", 32'(out_valid2), 0);
    chk("clr_cap_count2", 32'(count2), 0);

    // Reset mid-operation drops contents without a clock edge.
    cap_en = 1; q_in = 8'hAB;
    @(posedge clock); #1;
    q_in = 8'hCD;
    @(posedge clock); #1;
    cap_en = 0;
    chk("pre_rst_count", 32'(count), 2);
    chk("pre_rst_data", 32'(out_data), 32'hAB);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_pv", 32'(period_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("after_mid_rst_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_capture_fifo.md
Name: lfsr_capture_fifo

Overview:
- Downstream consumer of the memory-mapped LFSR application unit.
- Samples the unit's Q output on enabled cycles into a small FIFO and presents the samples on a valid/ready stream, e.g. to a UART/host packer.
- Also measures the LFSR sequence period and records overflow/drop statistics for software readback.

Parameters:
- n, 8, LFSR word width; must match the application unit's n.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- PW, 16, period counter width in bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous clear of FIFO, flags, counters and period FSM.
- cap_en  in  1  capture strobe; high on cycles where Q_in holds a new LFSR value (RUN/STEP).
- Q_in  in  n  LFSR value from the application unit's Q.
- out_data  out  n  FIFO head sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid and out_ready are both high.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one sample dropped.
- drop_cnt  out  8  dropped-sample count, saturates at 255.
- period  out  PW  measured sequence period.
- period_valid  out  1  period measurement complete.

Behaviour:
- Reset:
  - Asynchronous and active-high; clock is the single clock domain.
  - While reset is high: out_valid=0, out_data=0, count=0, overflow=0, drop_cnt=0, period=0, period_valid=0, FSM=IDLE, pointers=0.
  - Reset mid-operation discards FIFO contents immediately, without waiting for a clock edge.
- FIFO storage:
  - Circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count tracks occupancy; full = (count==DEPTH), empty = (count==0).
- Push and pop conditions:
  - push = cap_en.
  - pop = out_valid & out_ready.
- Latency: no fall-through. A sample pushed into an empty FIFO appears with out_valid=1 on the cycle after the capturing edge.
- out_data:
  - out_data = mem[rd_ptr], read combinationally from storage.
  - It must remain stable while out_valid=1 and out_ready=0.
- Push, pop and full interaction:
  - Push when not full: write mem[wr_ptr], then advance wr_ptr.
  - Push when full with no simultaneous pop: sample dropped, overflow<=1, drop_cnt<=drop_cnt+1 (saturating). Contents and pointers are unchanged.
  - Push and pop together when full: both happen, count stays DEPTH, no drop.
  - Push and pop together when empty: pop is ignored (out_valid=0), so this is a push only.
  - Push and pop together otherwise: count unchanged, both pointers advance.
- Period FSM, states IDLE, COUNT, DONE:
  - IDLE: on the first push cycle, ref<=Q_in, cnt<=0, go to COUNT.
  - COUNT: each cap_en cycle sets cnt<=cnt+1.
    - If Q_in==ref: period<=cnt+1, period_valid<=1, go to DONE.
    - Else if cnt+1 == 2^PW-1: period<=all-ones, period_valid<=1, go to DONE (timeout).
    - Cycles with cap_en=0 are not counted.
  - DONE: holds period and period_valid until clear or reset.
  - The period FSM sees every capture, including dropped samples.
  - An all-zero lock-up state (Q_in==0 repeating) yields period=1.
- clear:
  - Acts like reset but synchronously.
  - Takes precedence over any same-cycle push or pop; the sample at that edge is not stored and not counted.
  - The next cap_en after clear re-arms the FSM in IDLE.

Test Plan:
- Async reset asserted at 3 ns, mid-cycle -> all outputs 0 immediately. After release: count=0, out_valid=0, period_valid=0.
- n=8, out_ready=0; capture 0x78, 0x3C, 0x1E on three cycles -> count=3, out_data=0x78. Then out_ready=1 -> pops 0x78, 0x3C, 0x1E on consecutive cycles, then out_valid=0.
- out_ready=0; capture 10 values 0x01..0x0A -> count=8, overflow=1, drop_cnt=2. Draining yields 0x01..0x08 in order, with pointers wrapping correctly.
- FIFO full; hold cap_en=1 and out_ready=1 for 4 cycles -> count stays 8, drop_cnt unchanged, output order preserved.
- Capture 0x01, 0x02, 0x04, 0x08, 0x10, 0x01 with one cap_en=0 gap between the 3rd and 4th captures -> period=5 and period_valid=1 one cycle after the 6th capture. Then pulse clear -> period=0, period_valid=0, count=0.
- PW=4; capture 16 distinct non-repeating values -> period=4'hF and period_valid=1 after the 16th capture (timeout). A clear issued in the same cycle as a capture -> count=0, and that sample is not stored.
